// File: rtl/md4_crack_sched.sv
// md4_crack_sched: walks the lowercase keyspace, launching md4block and hashchecker once per candidate.
// Define MD4_CRACK_SCHED_TIMEOUT_EN to add the wait-state watchdog and the timeout_err output.
module md4_crack_sched #(
  parameter int         MIN_LEN        = 1,
  parameter int         MAX_LEN        = 4,
  parameter int         CHARSET_SIZE   = 26,
  parameter logic [7:0] CHAR_BASE      = 8'h61
`ifdef MD4_CRACK_SCHED_TIMEOUT_EN
  , parameter int       TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  output logic [159:0] passwd_chars,
  output logic [7:0]   passwd_len,
  output logic         md4_irdy,
  input  logic         md4_ordy,
  output logic         checker_checkrdy,
  input  logic         checker_resultrdy,
  input  logic         checker_matchfound,
  output logic         busy,
  output logic         done,
  output logic         match_found,
  output logic [159:0] match_chars,
  output logic [7:0]   match_len,
  output logic [31:0]  candidates_tried
`ifdef MD4_CRACK_SCHED_TIMEOUT_EN
  , output logic       timeout_err
`endif
);
  localparam int            DW        = (CHARSET_SIZE > 1) ? $clog2(CHARSET_SIZE) : 1;
  localparam logic [DW-1:0] DIGIT_MAX = DW'(CHARSET_SIZE - 1);
  localparam logic [7:0]    MIN_LEN_B = 8'(MIN_LEN);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, SETUP, LAUNCH, WAIT_MD4, CHECK, WAIT_CHK, ADVANCE, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] digit_q   [MAX_LEN];
  logic [DW-1:0] digit_d   [MAX_LEN];
  logic [DW-1:0] inc_digit [MAX_LEN];
  logic          carry_out;
  logic [7:0]    len_q, len_d;
  logic          pw_en_q, pw_en_d;
  logic          mf_q, mf_d;
  logic [159:0]  mc_q, mc_d;
  logic [7:0]    ml_q, ml_d;
  logic [31:0]   cnt_q, cnt_d;
`ifdef MD4_CRACK_SCHED_TIMEOUT_EN
  logic [15:0]   wd_q, wd_d;
  logic          to_q, to_d;
`endif

  // Odometer: position len-1 is least significant; carry ripples toward position 0.
  always_comb begin
    logic carry;
    carry = 1'b1;
    for (int i = MAX_LEN - 1; i >= 0; i--) begin
      inc_digit[i] = digit_q[i];
      if (carry && (8'(i) < len_q)) begin
        if (digit_q[i] == DIGIT_MAX) begin
          inc_digit[i] = '0;
        end else begin
          inc_digit[i] = digit_q[i] + 1'b1;
          carry        = 1'b0;
        end
      end
    end
    carry_out = carry;
  end

  for (genvar gi = 0; gi < 20; gi++) begin : g_chars
    if (gi < MAX_LEN) begin : g_used
      assign passwd_chars[159-8*gi -: 8] = (pw_en_q && (8'(gi) < len_q)) ?
                                           (CHAR_BASE + 8'(digit_q[gi])) : 8'h00;
    end else begin : g_unused
      assign passwd_chars[159-8*gi -: 8] = 8'h00;
    end
  end

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    len_d   = len_q;
    pw_en_d = pw_en_q;
    mf_d    = mf_q;
    mc_d    = mc_q;
    ml_d    = ml_q;
    cnt_d   = cnt_q;
`ifdef MD4_CRACK_SCHED_TIMEOUT_EN
    wd_d    = wd_q;
    to_d    = to_q;
`endif
    // abort freezes every register except the state itself.
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = SETUP;
            for (int i = 0; i < MAX_LEN; i++) digit_d[i] = '0;
            len_d   = MIN_LEN_B;
            pw_en_d = 1'b1;
            cnt_d   = '0;
            mf_d    = 1'b0;
            mc_d    = '0;
            ml_d    = '0;
`ifdef MD4_CRACK_SCHED_TIMEOUT_EN
            to_d    = 1'b0;
`endif
          end
        end
        SETUP: state_d = LAUNCH;
        LAUNCH: begin
          state_d = WAIT_MD4;
`ifdef MD4_CRACK_SCHED_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
        WAIT_MD4: begin
          if (md4_ordy) begin
            state_d = CHECK;
`ifdef MD4_CRACK_SCHED_TIMEOUT_EN
          end else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
            state_d = DONE;
            mf_d    = 1'b0;
            to_d    = 1'b1;
          end else begin
            wd_d    = wd_q + 16'd1;
`endif
          end
        end
        CHECK: begin
          state_d = WAIT_CHK;
`ifdef MD4_CRACK_SCHED_TIMEOUT_EN
          wd_d    = '0;
`endif
        end
        WAIT_CHK: begin
          if (checker_resultrdy) begin
            if (cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
            if (checker_matchfound) begin
              mf_d    = 1'b1;
              mc_d    = passwd_chars;
              ml_d    = len_q;
              state_d = DONE;
            end else begin
              state_d = ADVANCE;
            end
`ifdef MD4_CRACK_SCHED_TIMEOUT_EN
          end else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
            state_d = DONE;
            mf_d    = 1'b0;
            to_d    = 1'b1;
          end else begin
            wd_d    = wd_q + 16'd1;
`endif
          end
        end
        ADVANCE: begin
          digit_d = inc_digit;
          if (!carry_out) begin
            state_d = SETUP;
          end else if (len_q < MAX_LEN_B) begin
            len_d   = len_q + 8'd1;
            state_d = SETUP;
          end else begin
            mf_d    = 1'b0;
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      for (int i = 0; i < MAX_LEN; i++) digit_q[i] <= '0;
      len_q   <= MIN_LEN_B;
      pw_en_q <= 1'b0;
      mf_q    <= 1'b0;
      mc_q    <= '0;
      ml_q    <= '0;
      cnt_q   <= '0;
`ifdef MD4_CRACK_SCHED_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      len_q   <= len_d;
      pw_en_q <= pw_en_d;
      mf_q    <= mf_d;
      mc_q    <= mc_d;
      ml_q    <= ml_d;
      cnt_q   <= cnt_d;
`ifdef MD4_CRACK_SCHED_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  assign passwd_len       = len_q;
  assign md4_irdy         = (state_q == LAUNCH);
  assign checker_checkrdy = (state_q == CHECK);
  assign busy             = (state_q != IDLE) && (state_q != DONE);
  assign done             = (state_q == DONE);
  assign match_found      = mf_q;
  assign match_chars      = mc_q;
  assign match_len        = ml_q;
  assign candidates_tried = cnt_q;
`ifdef MD4_CRACK_SCHED_TIMEOUT_EN
  assign timeout_err      = to_q;
`endif

endmodule
